vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Schedules all accesses to a single-port 1K x 8 video RAM between three requesters: the video scan fetch, the 8080 CPU, and a hardware fill engine that clears or fills the whole RAM.
- Sits between the CPU bus decode / video timing logic and one spram instance.
- Replaces the dual-port VRAM, freeing a block RAM port for future cores such as CoMotion and Hustle.

Parameters:
- ADDR_W, 10, VRAM address width (RAM depth = 2^ADDR_W).
- DATA_W, 8, VRAM data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- vid_req  in  1  one-cycle strobe: video fetch request (issued on ce_vid).
- vid_addr  in  ADDR_W  video fetch address {V[7:3],H[7:3]}.
- vid_data  out  DATA_W  video read data, valid when vid_valid is high.
- vid_valid  out  1  one-cycle strobe, one cycle after the vid_req grant.
- cpu_req  in  1  level; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, valid with cpu_ack.
- cpu_ack  out  1  one-cycle completion strobe.
- fill_start  in  1  one-cycle strobe: start a fill.
- fill_value  in  DATA_W  fill data, sampled at fill_start.
- fill_busy  out  1  high while a fill is in progress.
- fill_done  out  1  one-cycle strobe when the final fill write has been issued.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data (1-cycle registered read latency).

Behaviour:
- Reset: all outputs 0; fill FSM in IDLE; fill counter 0; captured fill value 0; the pending-owner pipeline register is cleared.

Arbitration:
- Exactly one grant per cycle; the RAM port outputs are driven combinationally from the grant.
- Fixed priority: video > CPU > fill.
- Video is never stalled. vid_req arrives at most once every 4 cycles, so the CPU is guaranteed a slot within 2 cycles.
- No-grant cycle: ram_we = 0 and ram_addr holds its previous value.

Timing and pipeline:
- Latency: grant in cycle N; vid_valid/vid_data or cpu_ack/cpu_rdata are asserted in cycle N+1.
- Data is taken from ram_rdata in N+1 via a registered owner tag (NONE/VID/CPU/FILL).
- A CPU write also acks in N+1; cpu_rdata is then don't-care.
- CPU is not re-granted in the cycle its ack is asserted. This prevents a double access while the requester drops cpu_req.
- vid_data and cpu_rdata hold their last values between strobes.

Fill FSM:
- States and transitions:
  - IDLE: on fill_start, capture fill_value, counter = 0, go to FILL.
  - FILL: when granted, write the captured value at the counter address, then counter += 1. If the counter was 2^ADDR_W-1, go to DONE.
  - DONE: pulse fill_done for one cycle, then go to IDLE.
- fill_busy = 1 in FILL and DONE.
- fill_start while busy is ignored; the captured value is unchanged.
- A CPU write during a fill wins its slot. If its address has not yet been reached by the counter, the fill later overwrites it (documented behaviour). Addresses already filled keep the CPU data.
- The counter does not wrap mid-fill. It wraps to 0 only after the terminal write.

Simultaneous events and reset:
- vid_req + cpu_req + fill pending in the same cycle: video is served; CPU is served in the next free cycle; fill waits.
- Asynchronous reset mid-fill or mid-access aborts the operation. No ack or done is issued, and the RAM content is undefined for the partial fill.

Optional Feature:
VRAM_ARB_CPU_VBLANK_EN
- Defined: adds input port vblank (1 bit). CPU writes are eligible for grant only while vblank = 1; CPU reads are always eligible. This matches the original board's write window. A pending write holds cpu_req with no ack until vblank rises. Fill is unaffected.
- Undefined: no vblank port; CPU writes are granted at any time, per normal priority.

Test Plan:
- Reset release, idle inputs -> all outputs 0, ram_we = 0, fill_busy = 0.
- vid_req with vid_addr = 0x123, RAM[0x123] = 0x5A -> ram_addr = 0x123 the same cycle; vid_valid = 1 and vid_data = 0x5A the next cycle.
- cpu_req write 0x3FF <= 0xA5 in the same cycle as vid_req at 0x001 -> video granted first; CPU write issued next cycle; cpu_ack one cycle later; a subsequent CPU read of 0x3FF returns 0xA5.
- fill_start with fill_value = 0x20 and no other traffic -> 1024 consecutive writes at 0x000..0x3FF; fill_done 1025 cycles after fill_start; all locations read back as 0x20; a second fill_start mid-fill is ignored.
- Fill running with vid_req every 4 cycles and CPU write to 0x000 after the fill passes it -> video never delayed; RAM[0x000] holds the CPU data; total fill time = 1024 + number of stolen slots.
- With VRAM_ARB_CPU_VBLANK_EN: CPU write while vblank = 0 -> no ack for 50 cycles; vblank rises -> write granted within 2 cycles; a CPU read with vblank = 0 acks in 2 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port 1K x 8 VRAM scheduler for video scan, 8080 CPU and fill engine.
// Optional `VRAM_ARB_CPU_VBLANK_EN adds a vblank input limiting CPU writes to the vblank window.
module vram_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
`ifdef VRAM_ARB_CPU_VBLANK_EN
  input  logic              vblank,
`endif
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  output logic              vid_valid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU,
    OWN_FILL
  } own_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DONE
  } fill_st_t;

  own_t              r_own;
  fill_st_t          r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_val;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              r_busy;
  logic              r_done;

  logic w_cpu_win;
  logic w_cpu_elig;
  logic w_gnt_vid;
  logic w_gnt_cpu;
  logic w_gnt_fill;

`ifdef VRAM_ARB_CPU_VBLANK_EN
  assign w_cpu_win = !cpu_we || vblank;
`else
  assign w_cpu_win = 1'b1;
`endif

  // The ack cycle blocks a re-grant while the requester drops cpu_req.
  assign w_cpu_elig = cpu_req && w_cpu_win && (r_own != OWN_CPU);
  assign w_gnt_vid  = vid_req;
  assign w_gnt_cpu  = !vid_req && w_cpu_elig;
  assign w_gnt_fill = !vid_req && !w_cpu_elig && (r_state == S_FILL);

  always_comb begin
    ram_addr  = r_addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (1'b1)
      w_gnt_vid: begin
        ram_addr = vid_addr;
      end
      w_gnt_cpu: begin
        ram_addr  = cpu_addr;
        ram_we    = cpu_we;
        ram_wdata = cpu_we ? cpu_wdata : '0;
      end
      w_gnt_fill: begin
        ram_addr  = r_cnt;
        ram_we    = 1'b1;
        ram_wdata = r_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_own       <= OWN_NONE;
      r_addr_q    <= '0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_addr_q <= ram_addr;
      if (r_own == OWN_VID) r_vid_data <= ram_rdata;
      if (r_own == OWN_CPU) r_cpu_rdata <= ram_rdata;
      unique case (1'b1)
        w_gnt_vid:  r_own <= OWN_VID;
        w_gnt_cpu:  r_own <= OWN_CPU;
        w_gnt_fill: r_own <= OWN_FILL;
        default:    r_own <= OWN_NONE;
      endcase
    end
  end

  // Read data is steered straight from the RAM in the strobe cycle, then held.
  assign vid_valid = (r_own == OWN_VID);
  assign cpu_ack   = (r_own == OWN_CPU);
  assign vid_data  = vid_valid ? ram_rdata : r_vid_data;
  assign cpu_rdata = cpu_ack ? ram_rdata : r_cpu_rdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_val   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (fill_start) begin
            r_val   <= fill_value;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_gnt_fill) begin
            r_cnt <= r_cnt + ADDR_W'(1);
            if (r_cnt == '1) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign fill_busy = r_busy;
  assign fill_done = r_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: vector table plus scoreboard bench for vram_arbiter.
// Models a 1-cycle registered-read spram behind the arbiter.
module tb_vram_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n;
`ifdef VRAM_ARB_CPU_VBLANK_EN
  logic          vblank;
`endif
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          fill_start;
  logic [DW-1:0] fill_value;
  logic          fill_busy;
  logic          fill_done;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef VRAM_ARB_CPU_VBLANK_EN
    .vblank     (vblank),
`endif
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .vid_valid  (vid_valid),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_ack    (cpu_ack),
    .fill_start (fill_start),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  function automatic logic [7:0] minit(int i);
    logic [7:0] v;
    v = 8'(i) ^ 8'hC0;
    if (i == 'h123) v = 8'h5A;
    return v;
  endfunction

  logic [DW-1:0] mem [N];
  always @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) mem[i] <= minit(i);
      ram_rdata <= '0;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic       vr;
    logic [9:0] va;
    logic       cr;
    logic       cw;
    logic [9:0] ca;
    logic [7:0] cd;
    logic [9:0] ea;
    logic       ew;
    logic [7:0] ed;
    logic [1:0] own;
  } vec_t;

  exp_t       q[$];
  logic [7:0] ref_m [N];
  vec_t       tv [12];
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (vid_valid || cpu_ack) begin
      if (q.size() == 0) begin
        chk("unexpected strobe", {vid_valid, cpu_ack}, 2'b00);
      end else begin
        e = q.pop_front();
        chk("strobe kind", {vid_valid, cpu_ack}, (e.kind == 2'd1) ? 2'b10 : 2'b01);
        if (e.kind == 2'd1) chk("vid_data", vid_data, e.data);
        else if (e.kind == 2'd2) chk("cpu_rdata", cpu_rdata, e.data);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic we, input logic [9:0] a, input logic [7:0] d,
                            input int lat);
    int n;
    n = 0;
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    if (we) begin
      q.push_back({2'd3, 8'h00});
      ref_m[a] = d;
    end else begin
      q.push_back({2'd2, ref_m[a]});
    end
    do begin
      cyc();
      n++;
    end while (!cpu_ack && n < lat + 5);
    chk("cpu ack", cpu_ack, 1'b1);
    chk("cpu latency", n, lat);
    cpu_req = 1'b0;
    cyc();
  endtask

  task automatic vid_read(input logic [9:0] a);
    vid_req = 1'b1;
    vid_addr = a;
    q.push_back({2'd1, ref_m[a]});
    #1;
    chk("vid addr same cycle", ram_addr, a);
    cyc();
    vid_req = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_k, nw, bad, nvid, vbad, na, n;

    //           vr va      cr cw ca      cd     ea      ew ed     own
    tv[0]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 10'h000, 1'b0, 8'h00, 2'd0};
    tv[1]  = '{1'b1, 10'h123, 1'b0, 1'b0, 10'h000, 8'h00, 10'h123, 1'b0, 8'h00, 2'd1};
    tv[2]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 10'h123, 1'b0, 8'h00, 2'd0};
    tv[3]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h010, 8'h00, 10'h010, 1'b0, 8'h00, 2'd2};
    tv[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h050, 8'h00, 10'h010, 1'b0, 8'h00, 2'd0};
    tv[5]  = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 8'h33, 10'h020, 1'b1, 8'h33, 2'd3};
    tv[6]  = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 10'h020, 1'b0, 8'h00, 2'd0};
    tv[7]  = '{1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 8'h00, 10'h020, 1'b0, 8'h00, 2'd2};
    tv[8]  = '{1'b1, 10'h020, 1'b1, 1'b0, 10'h030, 8'h00, 10'h020, 1'b0, 8'h00, 2'd1};
    tv[9]  = '{1'b1, 10'h3FE, 1'b1, 1'b1, 10'h040, 8'h77, 10'h3FE, 1'b0, 8'h00, 2'd1};
    tv[10] = '{1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 8'h77, 10'h040, 1'b1, 8'h77, 2'd3};
    tv[11] = '{1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 8'h00, 10'h040, 1'b0, 8'h00, 2'd0};

    for (int i = 0; i < N; i++) ref_m[i] = minit(i);
    reset_n = 1'b0;
`ifdef VRAM_ARB_CPU_VBLANK_EN
    vblank = 1'b1;
`endif
    vid_req = 1'b0;
    vid_addr = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_wdata = '0;
    fill_start = 1'b0;
    fill_value = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("reset outputs",
        {vid_data, vid_valid, cpu_rdata, cpu_ack, fill_busy, fill_done, ram_we, ram_wdata}, 0);
    chk("reset ram_addr", ram_addr, 0);

    for (int i = 0; i < 12; i++) begin
      vid_req = tv[i].vr;
      vid_addr = tv[i].va;
      cpu_req = tv[i].cr;
      cpu_we = tv[i].cw;
      cpu_addr = tv[i].ca;
      cpu_wdata = tv[i].cd;
      #1;
      chk($sformatf("vec%0d port", i), {ram_addr, ram_we, ram_wdata},
          {tv[i].ea, tv[i].ew, tv[i].ed});
      case (tv[i].own)
        2'd1: q.push_back({2'd1, ref_m[tv[i].va]});
        2'd2: q.push_back({2'd2, ref_m[tv[i].ca]});
        2'd3: begin
          q.push_back({2'd3, 8'h00});
          ref_m[tv[i].ca] = tv[i].cd;
        end
        default: ;
      endcase
      cyc();
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    cyc();
    cyc();
    chk("vid_data hold", vid_data, 8'h3E);

    // video and CPU write in the same cycle, then read back
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 10'h3FF;
    cpu_wdata = 8'hA5;
    vid_req = 1'b1;
    vid_addr = 10'h001;
    q.push_back({2'd1, ref_m[10'h001]});
    #1;
    chk("collide vid first", {ram_addr, ram_we}, {10'h001, 1'b0});
    cyc();
    vid_req = 1'b0;
    #1;
    chk("collide cpu next", {ram_addr, ram_we, ram_wdata}, {10'h3FF, 1'b1, 8'hA5});
    q.push_back({2'd3, 8'h00});
    ref_m[10'h3FF] = 8'hA5;
    cyc();
    chk("collide ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    cyc();
    cpu_access(1'b0, 10'h3FF, 8'h00, 1);

    // plain fill, with a second start ignored mid-way
    done_k = 0;
    nw = 0;
    bad = 0;
    fill_value = 8'h20;
    fill_start = 1'b1;
    for (int k = 1; k <= 1200 && done_k == 0; k++) begin
      cyc();
      fill_start = (k == 500);
      fill_value = (k == 500) ? 8'h77 : 8'h20;
      #1;
      if (k == 500) chk("fill busy mid", fill_busy, 1'b1);
      if (ram_we) begin
        if (ram_addr != 10'(nw) || ram_wdata != 8'h20) bad++;
        nw++;
      end
      if (fill_done) done_k = k;
    end
    fill_start = 1'b0;
    chk("fill done cycle", done_k, 1025);
    chk("fill write count", nw, 1024);
    chk("fill write seq", bad, 0);
    cyc();
    chk("fill idle after", {fill_busy, fill_done}, 2'b00);
    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== 8'h20) bad++;
    chk("fill contents", bad, 0);
    for (int i = 0; i < N; i++) ref_m[i] = 8'h20;
    vid_read(10'h000);
    vid_read(10'h3FF);
    cyc();

    // fill under video and CPU traffic
    done_k = 0;
    nvid = 0;
    vbad = 0;
    fill_value = 8'h3C;
    fill_start = 1'b1;
    for (int k = 1; k <= 2000 && done_k == 0; k++) begin
      cyc();
      if (cpu_ack) cpu_req = 1'b0;
      fill_start = 1'b0;
      vid_req = (k % 4 == 1);
      vid_addr = 10'h001;
      if (vid_req) q.push_back({2'd1, (k == 1) ? 8'h20 : 8'h3C});
      if (k == 21) begin
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 10'h000;
        cpu_wdata = 8'hC3;
        q.push_back({2'd3, 8'h00});
      end
      #1;
      if (vid_req && ram_addr != 10'h001) vbad++;
      if (fill_done) done_k = k;
      else if (vid_req) nvid++;
    end
    cyc();
    vid_req = 1'b0;
    cpu_req = 1'b0;
    chk("video never delayed", vbad, 0);
    chk("stolen fill time", done_k, 1024 + 1 + nvid + 1);
    for (int i = 0; i < N; i++) ref_m[i] = 8'h3C;
    ref_m[0] = 8'hC3;
    cyc();
    vid_read(10'h000);
    vid_read(10'h3FF);
    cyc();

`ifdef VRAM_ARB_CPU_VBLANK_EN
    vblank = 1'b0;
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 10'h155;
    cpu_wdata = 8'h99;
    q.push_back({2'd3, 8'h00});
    ref_m[10'h155] = 8'h99;
    na = 0;
    repeat (50) begin
      cyc();
      if (cpu_ack) na++;
    end
    chk("vblank write held", na, 0);
    vblank = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!cpu_ack && n < 8);
    chk("vblank write ack", cpu_ack, 1'b1);
    chk("vblank write lat", n <= 3, 1'b1);
    cpu_req = 1'b0;
    cyc();
    vblank = 1'b0;
    cpu_access(1'b0, 10'h155, 8'h00, 1);
    vblank = 1'b1;
`else
    na = 0;
    n = 0;
`endif

    repeat (3) cyc();
    chk("scoreboard drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
